decrypt_code: RTL
=================

DECRYPT_CODE -- requirements
Module: decrypt_code

Interface
REQ-001 The block SHALL have parameter FRAME_BYTES, default 4, meaning the number of decrypted bytes per frame (legal range 1..255).
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_start, input, 1 bit: a one-cycle pulse marking that i_code carries bit 0 of a new frame this cycle.
REQ-005 The block SHALL have port i_code, input, 1 bit: the encrypted serial bit, one bit per clock, continuous within a frame.
REQ-006 The block SHALL have port o_data, output, 1 bit: the combinational decrypted bit i_code XOR keystream bit.
REQ-007 The block SHALL have port o_data_valid, output, 1 bit: combinational, high when state is RUN or i_start is high.
REQ-008 The block SHALL have port o_byte, output, 8 bits: the last completed decrypted byte, LSB = first received bit.
REQ-009 The block SHALL have port o_byte_valid, output, 1 bit: a registered one-cycle pulse when o_byte updates.
REQ-010 The block SHALL have port o_frame_done, output, 1 bit: a registered one-cycle pulse coincident with the o_byte_valid of the last byte of a frame.
REQ-011 The block SHALL have port o_resync, output, 1 bit: a registered one-cycle pulse when i_start arrives while in RUN.
REQ-012 The block SHALL have port o_busy, output, 1 bit: registered, high in RUN.

Function
REQ-013 The keystream SHALL come from a 4-bit LFSR with seed 4'b0001 and step next[2:0]=cur[3:1], next[3]=cur[3]^cur[0]; the key bit is cur[0]; the period is 15.
REQ-014 The state machine SHALL have two states: IDLE and RUN.
REQ-015 In IDLE without i_start, the LFSR SHALL hold, o_data SHALL be 0, and o_data_valid SHALL be 0.
REQ-016 On an i_start cycle in either state, the key bit SHALL be 1 (seed bit 0), the LFSR SHALL load step(seed)=4'b1000, the bit counter SHALL be 1, the byte counter SHALL be 0, bit 0 of the shift register SHALL be captured, and the state SHALL be RUN.
REQ-017 In RUN without i_start, the LFSR SHALL step every clock and the decrypted bit SHALL be shifted into the byte assembler at position bit-counter.
REQ-018 When the 8th bit of a byte is sampled at edge n, o_byte SHALL update and o_byte_valid SHALL be high for the cycle following edge n (latency 1 clock), and the bit counter SHALL wrap to 0.
REQ-019 When byte FRAME_BYTES completes, o_frame_done SHALL pulse with o_byte_valid and the state SHALL return to IDLE with the LFSR reloaded to the seed.
REQ-020 i_start on the same cycle as the final bit of a frame SHALL take priority: the final byte is discarded, o_resync SHALL pulse, o_frame_done SHALL NOT pulse, and a new frame SHALL begin.
REQ-021 i_start mid-frame SHALL discard the partial byte, pulse o_resync, and restart as in REQ-016.
REQ-022 o_byte SHALL hold its value between o_byte_valid pulses.

Reset
REQ-023 While i_reset_n is 0, the block SHALL force the state to IDLE, the LFSR to 4'b0001, all counters to 0, o_byte to 8'h00, and o_byte_valid, o_frame_done, o_resync and o_busy to 0, regardless of the clock.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no pulses emitted, and a new i_start SHALL be required after release.

Structure
REQ-025 A shared package SHALL hold the LFSR width (4), seed (4'b0001), the state encoding and the byte width (8).
REQ-026 The block SHALL contain one sub-module, lfsr_keygen (load, step, key-bit out), reusable by the encrypt side.

Verification
REQ-027 The bench SHALL drive i_start then code bits LSB-first of 0xF1 -> o_byte=0x00, with o_byte_valid exactly 1 cycle after the 8th bit.
REQ-028 The bench SHALL drive the 2nd byte code 0x9A (keystream bits 8..15) -> o_byte=0x00, and code 0x00 -> o_byte=0x9A.
REQ-029 The bench SHALL run FRAME_BYTES=4 of encrypted 0xA5 from an encrypt_code instance started at the same i_start -> four o_byte=0xA5, o_frame_done with the 4th, then o_busy=0.
REQ-030 The bench SHALL pulse i_start at bit 5 of byte 2 -> o_resync pulse, no byte emitted for the partial byte, and the next 8 bits decrypt with the seed realigned (code 0xF1 -> 0x00).
REQ-031 The bench SHALL assert i_reset_n=0 mid-byte, asynchronously between edges -> outputs cleared immediately, and no o_byte_valid until a new i_start plus 8 bits.
REQ-032 The bench SHALL drive i_start coincident with the 32nd bit -> o_resync=1, o_frame_done=0, o_busy stays 1.

Source files
------------

// File: rtl/decrypt_code_pkg.sv
// Shared constants, state encoding and LFSR step for the serial decryptor.
// Used by decrypt_code, lfsr_keygen and any matching encrypt side.
package decrypt_code_pkg;

  localparam int LFSR_W = 4;
  localparam int BYTE_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b0001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(
    input logic [LFSR_W-1:0] cur
  );
    return {cur[LFSR_W-1] ^ cur[0], cur[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/decrypt_code_if.sv
// Serial decrypt bus: start/code in, plain bit and byte results out.
// master drives start/code, slave returns data/byte/status.
interface decrypt_code_if;
  import decrypt_code_pkg::*;

  logic              start;
  logic              code;
  logic              data;
  logic              data_vld;
  logic [BYTE_W-1:0] dbyte;
  logic              byte_vld;
  logic              frame_done;
  logic              resync;
  logic              busy;

  modport master (
    output start, code,
    input  data, data_vld, dbyte, byte_vld,
    input  frame_done, resync, busy
  );

  modport slave (
    input  start, code,
    output data, data_vld, dbyte, byte_vld,
    output frame_done, resync, busy
  );

endinterface

// File: rtl/decrypt_code_lfsr_keygen.sv
// 4-bit keystream LFSR: load a value, or step once per clock; key = bit 0.
// Ports: i_clk, i_reset_n, i_load, i_load_val, i_step, o_key.
module lfsr_keygen
  import decrypt_code_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_load_val,
  input  logic              i_step,
  output logic              o_key
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (i_load) begin
      r_lfsr <= i_load_val;
    end else if (i_step) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign o_key = r_lfsr[0];

endmodule

// File: rtl/decrypt_code.sv
// Serial stream decryptor: XOR with LFSR keystream, byte/frame assembly.
// Ports: i_clk, i_reset_n, i_start, i_code in; o_data, o_byte, status out.
module decrypt_code
  import decrypt_code_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic              i_code,
  output logic              o_data,
  output logic              o_data_valid,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_byte_valid,
  output logic              o_frame_done,
  output logic              o_resync,
  output logic              o_busy
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  state_e            r_state;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_byte_cnt;
  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-1:0] r_byte;
  logic              r_byte_valid;
  logic              r_frame_done;
  logic              r_resync;
  logic              r_busy;

  logic              w_run;
  logic              w_run_bit;
  logic              w_last_bit;
  logic              w_frame_end;
  logic              w_lfsr_key;
  logic              w_key;
  logic              w_bit;
  logic              w_load;
  logic [LFSR_W-1:0] w_load_val;

  assign w_run       = (r_state == ST_RUN);
  assign w_run_bit   = w_run & ~i_start;
  assign w_last_bit  = w_run_bit & (r_bit_cnt == 3'd7);
  assign w_frame_end = w_last_bit & (r_byte_cnt == LAST_BYTE);

  // A start cycle always uses the seed's key bit, wherever the LFSR is.
  assign w_key = i_start ? LFSR_SEED[0] : w_lfsr_key;
  assign w_bit = i_code ^ w_key;

  assign o_data_valid = w_run | i_start;
  assign o_data       = o_data_valid & w_bit;

  // Start consumes the seed this cycle, so preload its successor.
  assign w_load     = i_start | w_frame_end;
  assign w_load_val = i_start ? lfsr_step(LFSR_SEED) : LFSR_SEED;

  lfsr_keygen u_keygen (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_step     (w_run_bit),
    .o_key      (w_lfsr_key)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_resync     <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_resync     <= 1'b0;
      unique case (1'b1)
        i_start: begin
          r_resync   <= w_run;
          r_state    <= ST_RUN;
          r_busy     <= 1'b1;
          r_bit_cnt  <= 3'd1;
          r_byte_cnt <= '0;
          r_shift[0] <= w_bit;
        end
        w_run_bit: begin
          r_shift[r_bit_cnt] <= w_bit;
          r_bit_cnt          <= r_bit_cnt + 3'd1;
          if (w_last_bit) begin
            r_byte       <= {w_bit, r_shift[BYTE_W-2:0]};
            r_byte_valid <= 1'b1;
            if (w_frame_end) begin
              r_frame_done <= 1'b1;
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_byte_cnt   <= '0;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_done = r_frame_done;
  assign o_resync     = r_resync;
  assign o_busy       = r_busy;

endmodule
